// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_RISE = 3'd2,
    WAIT_FALL = 3'd3,
    DONE      = 3'd4
  } arb_state_e;

  localparam int BYTE_W = 8;

  // The counter must be able to hold the value busy_wait itself.
  function automatic int busy_cnt_w(input int busy_wait);
    return (busy_wait < 1) ? 1 : $clog2(busy_wait + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART transmitter signals seen by the arbiter
interface uart_arb_if import uart_arb_pkg::*; #(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_ready;
  logic [BYTE_W-1:0]         data_in;
  logic                      data_in_wr;
  logic                      busy_tx;
  logic [$clog2(NUM_REQ)-1:0] grant;
  logic                      active;

  modport master (
    input  req_valid, req_data, req_lock, busy_tx,
    output req_ready, data_in, data_in_wr, grant, active
  );

  modport slave (
    output req_valid, req_data, req_lock, busy_tx,
    input  req_ready, data_in, data_in_wr, grant, active
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker
// Winner is the lowest requesting index at or after ptr_i, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] winner_o,
  output logic                       any_o
);

  localparam int IW = $clog2(NUM_REQ);

  int   idx;
  logic found;

  always_comb begin
    winner_o = '0;
    any_o    = |req_i;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        winner_o = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter in front of a single UART transmitter
// One write pulse per byte, then wait for busy_tx to rise and fall (or time out) before the next.
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int NUM_REQ   = 2,
  parameter int BUSY_WAIT = 4
) (
  input logic        clk,
  input logic        reset,
  uart_arb_if.master bus
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = busy_cnt_w(BUSY_WAIT);

  arb_state_e         state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      ptr_q, ptr_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               wr_q, wr_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [GW-1:0]      pick_idx;
  logic               pick_any;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i    (bus.req_valid),
    .ptr_i    (ptr_q),
    .winner_o (pick_idx),
    .any_o    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      ready_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    ready_d = '0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.req_valid[grant_q]) begin
          wr_d             = 1'b1;
          ready_d[grant_q] = 1'b1;
          data_d           = bus.req_data[BYTE_W*grant_q +: BYTE_W];
          cnt_d            = '0;
          state_d          = WAIT_RISE;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RISE: begin
        if (bus.busy_tx) begin
          state_d = WAIT_FALL;
        end else begin
          // No busy response within the window: the byte is given up, not retried.
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(BUSY_WAIT)) begin
            state_d = DONE;
          end
        end
      end
      WAIT_FALL: begin
        if (!bus.busy_tx) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.req_lock[grant_q] && bus.req_valid[grant_q]) begin
          state_d = ISSUE;
        end else begin
          ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = ready_q;
  assign bus.data_in    = data_q;
  assign bus.data_in_wr = wr_q;
  assign bus.grant      = grant_q;
  assign bus.active     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int NUM_REQ   = 2;
  localparam int BUSY_WAIT = 4;
  localparam int BUSY_LEN  = 10;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic busy_r = 1'b0;

  always #5 clk = ~clk;

  uart_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0]         rq_data [NUM_REQ][8];
  int                 rq_len  [NUM_REQ];
  int                 rq_pos  [NUM_REQ];
  logic [NUM_REQ-1:0] lock_en = '0;
  logic [NUM_REQ-1:0] kill    = '0;
  logic               uart_en = 1'b1;
  int                 busy_left = 0;
  logic [NUM_REQ-1:0] took_s;
  logic               rst_s = 1'b1;
  logic [7:0]         prev_din = 8'h00;

  logic [7:0] log_data[$];
  int         log_gnt[$];
  int         log_cyc[$];

  assign bus.busy_tx = busy_r;

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rq_len[i] = 0;
      rq_pos[i] = 0;
      for (int k = 0; k < 8; k++) rq_data[i][k] = 8'h00;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]        = (rq_pos[i] < rq_len[i]) && !kill[i];
      bus.req_data[8*i +: 8]  = rq_data[i][rq_pos[i] & 7];
      bus.req_lock[i]         = lock_en[i] && (rq_pos[i] < rq_len[i]) && !kill[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Requesters pop on handshake; UART model raises busy the cycle after a write for BUSY_LEN cycles.
  always @(posedge clk) begin
    took_s = bus.req_valid & bus.req_ready;
    rst_s  = reset;
    cyc++;
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (took_s[i]) rq_pos[i]++;
    if (rst_s) begin
      busy_left = 0;
      busy_r    = 1'b0;
    end else if (busy_left > 0) begin
      busy_r = 1'b1;
      busy_left--;
    end else begin
      busy_r = 1'b0;
    end
    if (!rst_s && bus.data_in_wr && uart_en) busy_left = BUSY_LEN;
  end

  always @(negedge clk) begin
    if (cyc > 1) begin
      check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
      check("wr_while_busy", 32'(bus.data_in_wr && bus.busy_tx), 32'd0);
      if (!bus.data_in_wr && !rst_s) check("din_stable", 32'(bus.data_in), 32'(prev_din));
      prev_din = bus.data_in;
      if (bus.data_in_wr) begin
        log_data.push_back(bus.data_in);
        log_gnt.push_back(int'(bus.grant));
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic load(input int i, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input int n);
    rq_data[i][rq_pos[i] & 7]       = b0;
    rq_data[i][(rq_pos[i] + 1) & 7] = b1;
    rq_data[i][(rq_pos[i] + 2) & 7] = b2;
    rq_len[i] = rq_pos[i] + n;
  endtask

  task automatic clear_log();
    log_data.delete();
    log_gnt.delete();
    log_cyc.delete();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    do begin
      smp();
      n++;
    end while ((bus.active || busy_r || (rq_pos[0] < rq_len[0]) || (rq_pos[1] < rq_len[1])) && n < 600);
    check(tag, 32'(n < 600), 32'd1);
  endtask

  task automatic wait_wr(input string tag);
    int n = 0;
    do begin
      smp();
      n++;
    end while (!bus.data_in_wr && n < 50);
    check(tag, 32'(bus.data_in_wr), 32'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    smp();
    check("rst_active", 32'(bus.active), 32'd0);
    check("rst_wr", 32'(bus.data_in_wr), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_din", 32'(bus.data_in), 32'h00);
    step();
    reset = 1'b0;
    step();

    // Contention: both hold two bytes, no lock
    clear_log();
    load(0, 8'h11, 8'h11, 8'h00, 2);
    load(1, 8'h22, 8'h22, 8'h00, 2);
    wait_drain("cont_drain");
    check("cont_count", 32'(log_data.size()), 32'd4);
    check("cont_b0", 32'(log_data[0]), 32'h11);
    check("cont_b1", 32'(log_data[1]), 32'h22);
    check("cont_b2", 32'(log_data[2]), 32'h11);
    check("cont_b3", 32'(log_data[3]), 32'h22);
    check("cont_g0", 32'(log_gnt[0]), 32'd0);
    check("cont_g1", 32'(log_gnt[1]), 32'd1);
    check("cont_g2", 32'(log_gnt[2]), 32'd0);
    check("cont_g3", 32'(log_gnt[3]), 32'd1);

    // Lock: req0 sends ABC holding the grant, req1 waits
    step();
    clear_log();
    lock_en = 2'b01;
    load(0, 8'h41, 8'h42, 8'h43, 3);
    load(1, 8'h5A, 8'h00, 8'h00, 1);
    wait_drain("lock_drain");
    lock_en = 2'b00;
    check("lock_count", 32'(log_data.size()), 32'd4);
    check("lock_b0", 32'(log_data[0]), 32'h41);
    check("lock_b1", 32'(log_data[1]), 32'h42);
    check("lock_b2", 32'(log_data[2]), 32'h43);
    check("lock_b3", 32'(log_data[3]), 32'h5A);
    check("lock_g3", 32'(log_gnt[3]), 32'd1);

    // Single byte latency and handshake timing
    step();
    clear_log();
    load(0, 8'h41, 8'h00, 8'h00, 1);
    smp();
    check("sb_c0_wr", 32'(bus.data_in_wr), 32'd0);
    check("sb_c0_active", 32'(bus.active), 32'd0);
    smp();
    check("sb_c1_active", 32'(bus.active), 32'd1);
    check("sb_c1_grant", 32'(bus.grant), 32'd0);
    check("sb_c1_wr", 32'(bus.data_in_wr), 32'd0);
    smp();
    check("sb_c2_wr", 32'(bus.data_in_wr), 32'd1);
    check("sb_c2_din", 32'(bus.data_in), 32'h41);
    check("sb_c2_ready", 32'(bus.req_ready), 32'h1);
    smp();
    check("sb_c3_wr", 32'(bus.data_in_wr), 32'd0);
    check("sb_c3_ready", 32'(bus.req_ready), 32'h0);
    check("sb_c3_busy", 32'(busy_r), 32'd1);
    n = 0;
    while (busy_r && n < 50) begin
      smp();
      n++;
    end
    check("sb_busy_fell", 32'(busy_r), 32'd0);
    check("sb_wfall_active", 32'(bus.active), 32'd1);
    smp();
    check("sb_done_active", 32'(bus.active), 32'd1);
    smp();
    check("sb_idle_active", 32'(bus.active), 32'd0);
    check("sb_count", 32'(log_data.size()), 32'd1);

    // Timeout: no busy response, each byte gives up after BUSY_WAIT cycles
    step();
    clear_log();
    uart_en = 1'b0;
    load(0, 8'h77, 8'h78, 8'h00, 2);
    wait_drain("to_drain");
    uart_en = 1'b1;
    check("to_count", 32'(log_data.size()), 32'd2);
    check("to_b0", 32'(log_data[0]), 32'h77);
    check("to_b1", 32'(log_data[1]), 32'h78);
    check("to_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd7);

    // Withdrawal: req1 drops valid in its granted cycle
    step();
    clear_log();
    load(1, 8'h99, 8'h00, 8'h00, 1);
    step();
    kill = 2'b10;
    @(negedge clk);
    check("wd_c1_active", 32'(bus.active), 32'd1);
    check("wd_c1_grant", 32'(bus.grant), 32'd1);
    smp();
    check("wd_c2_active", 32'(bus.active), 32'd0);
    check("wd_c2_wr", 32'(bus.data_in_wr), 32'd0);
    step();
    rq_len[1] = rq_pos[1];
    kill      = 2'b00;
    smp();
    check("wd_c3_wr", 32'(bus.data_in_wr), 32'd0);
    check("wd_count", 32'(log_data.size()), 32'd0);

    // Reset in WAIT_FALL, then ptr restarts at requester 0
    step();
    clear_log();
    load(0, 8'hC3, 8'h00, 8'h00, 1);
    wait_wr("rs_wr_seen");
    repeat (4) smp();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    load(0, 8'hD1, 8'h00, 8'h00, 1);
    load(1, 8'hD2, 8'h00, 8'h00, 1);
    smp();
    check("rs_active", 32'(bus.active), 32'd0);
    check("rs_grant", 32'(bus.grant), 32'd0);
    check("rs_din", 32'(bus.data_in), 32'h00);
    check("rs_wr", 32'(bus.data_in_wr), 32'd0);
    check("rs_ready", 32'(bus.req_ready), 32'h0);
    smp();
    check("rs_c2_active", 32'(bus.active), 32'd1);
    check("rs_c2_grant", 32'(bus.grant), 32'd0);
    smp();
    check("rs_c3_wr", 32'(bus.data_in_wr), 32'd1);
    check("rs_c3_din", 32'(bus.data_in), 32'hD1);
    wait_drain("rs_drain");
    check("rs_count", 32'(log_data.size()), 32'd3);
    check("rs_b1", 32'(log_data[1]), 32'hD1);
    check("rs_b2", 32'(log_data[2]), 32'hD2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
